// File: rtl/decode_stage_p.sv
// decode_stage_p
//   Decode stage of an RV32I pipeline extended with a custom FILTER
//   instruction (opcode 0001011). Decodes i_instr, reads the register file
//   (with same-cycle writeback bypass) and registers everything EX needs.
//   While a FILTER operation is outstanding a small IDLE/BUSY FSM holds the
//   front end with o_stall_req and feeds bubbles to EX until the filter unit
//   pulses i_filt_done or the timeout expires.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   stall               hold every registered output (beats flush and bubbles)
//   flush               load a bubble (all registered outputs zero)
//   i_instr             instruction word being decoded
//   i_pc, i_pc4         pc and pc+4 of that instruction
//   i_wr_en/idx/data    writeback port into the register file
//   i_filt_done         one-cycle completion pulse from the filter unit
//   o_pc .. o_imm       registered datapath values for EX
//   o_ctrl              registered control bus:
//                         [0] reg1_sel (1: operand A is pc)
//                         [1] reg2_sel (1: operand B is imm)
//                         [3:2] alu_op (0 add, 1 reg-reg op, 2 reg-imm op, 3 pass B)
//                         [5:4] branch_op (0 none, 1 cond branch, 2 jal, 3 jalr)
//                         [6] mem_w_en  [8:7] wb_sel (0 alu, 1 mem, 2 pc4)
//                         [9] wb_en  [10] ebreak  [11] run_filter  [12] illegal
//                         [15:13] func3  [16] instr30
//   o_w_idx/o_rs1/o_rs2 registered rd/rs1/rs2 fields
//   o_wire_rs1/rs2      combinational rs1/rs2 fields for hazard detection
//   o_reg_a0            combinational value of x10 (bypassed)
//   o_stall_req         upstream stall while the filter FSM is BUSY
//   o_filt_busy         filter FSM state (1 = BUSY)
//   o_filt_err          sticky filter-timeout flag, cleared only by rst
//
// Flow control: there is no valid/ready pair. stall freezes the stage for
// the cycle it is high; flush or a busy filter replace the loaded values
// with an all-zero bubble. Priority is rst > stall > flush/busy > load.
module decode_stage_p #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int FILT_TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc4,
  input  logic            i_wr_en,
  input  logic [4:0]      i_wr_idx,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic            i_filt_done,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic [XLEN-1:0] o_reg1,
  output logic [XLEN-1:0] o_reg2,
  output logic [XLEN-1:0] o_imm,
  output logic [16:0]     o_ctrl,
  output logic [4:0]      o_w_idx,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_wire_rs1,
  output logic [4:0]      o_wire_rs2,
  output logic [XLEN-1:0] o_reg_a0,
  output logic            o_stall_req,
  output logic            o_filt_busy,
  output logic            o_filt_err
);

  localparam int            CW       = $clog2(FILT_TIMEOUT) + 1;
  localparam int            IW       = $clog2(NREG);
  localparam logic [5:0]    NREG_LIM = 6'(NREG);
  localparam logic [CW-1:0] TMO_LAST = CW'(FILT_TIMEOUT - 1);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FILTER = 7'b0001011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} filt_state_e;

  // ---------------------------------------------------------------- fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;

  assign opcode     = i_instr[6:0];
  assign rd         = i_instr[11:7];
  assign rs1        = i_instr[19:15];
  assign rs2        = i_instr[24:20];
  assign o_wire_rs1 = rs1;
  assign o_wire_rs2 = rs2;

  // --------------------------------------------------------- register file
  // Entry 0 exists only to keep indexing simple; it is never written.
  logic [XLEN-1:0] rf [NREG];
  logic            wr_hit;

  assign wr_hit = i_wr_en && (i_wr_idx != 5'd0) && ({1'b0, i_wr_idx} < NREG_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_hit) begin
      rf[i_wr_idx[IW-1:0]] <= i_wr_data;
    end
  end

  // Out-of-range indices read as zero; a write landing this edge is
  // forwarded so the consumer sees the new value without a bubble.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0]      idx,
                                               input logic [XLEN-1:0] stored,
                                               input logic            hit,
                                               input logic [4:0]      widx,
                                               input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] val;
    if (idx == 5'd0 || {1'b0, idx} >= NREG_LIM) val = '0;
    else if (hit && idx == widx)                val = wdata;
    else                                        val = stored;
    return val;
  endfunction

  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1_val  = read_reg(rs1, rf[rs1[IW-1:0]], wr_hit, i_wr_idx, i_wr_data);
  assign rs2_val  = read_reg(rs2, rf[rs2[IW-1:0]], wr_hit, i_wr_idx, i_wr_data);
  assign o_reg_a0 = read_reg(5'd10, rf[10], wr_hit, i_wr_idx, i_wr_data);

  // ---------------------------------------------------------------- decode
  logic        d_r1sel, d_r2sel, d_mw, d_wben, d_ebreak, d_runf, d_illegal;
  logic [1:0]  d_alu, d_br, d_wbsel;
  logic        known, use_rd, use_rs1, use_rs2, bad_idx;
  logic [31:0] imm32;
  logic [XLEN-1:0] d_imm;
  logic [16:0] d_ctrl;

  always_comb begin
    d_r1sel  = 1'b0;
    d_r2sel  = 1'b0;
    d_alu    = 2'd0;
    d_br     = 2'd0;
    d_mw     = 1'b0;
    d_wbsel  = 2'd0;
    d_wben   = 1'b0;
    d_ebreak = 1'b0;
    d_runf   = 1'b0;
    known    = 1'b1;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm32    = '0;
    case (opcode)
      OP_REG: begin
        d_alu = 2'd1; d_wben = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_IMM: begin
        d_r2sel = 1'b1; d_alu = 2'd2; d_wben = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_LOAD: begin
        d_r2sel = 1'b1; d_wbsel = 2'd1; d_wben = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        d_r2sel = 1'b1; d_mw = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        // ALU forms the target pc+imm; the comparison uses o_reg1/o_reg2.
        d_r1sel = 1'b1; d_r2sel = 1'b1; d_br = 2'd1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                 i_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        d_r1sel = 1'b1; d_r2sel = 1'b1; d_br = 2'd2; d_wbsel = 2'd2; d_wben = 1'b1;
        use_rd = 1'b1;
        imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                 i_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        d_r2sel = 1'b1; d_br = 2'd3; d_wbsel = 2'd2; d_wben = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_LUI: begin
        d_r2sel = 1'b1; d_alu = 2'd3; d_wben = 1'b1;
        use_rd = 1'b1;
        imm32 = {i_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        d_r1sel = 1'b1; d_r2sel = 1'b1; d_wben = 1'b1;
        use_rd = 1'b1;
        imm32 = {i_instr[31:12], 12'b0};
      end
      OP_SYSTEM: begin
        d_ebreak = (i_instr == 32'h0010_0073);
      end
      OP_FILTER: begin
        d_runf = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: known = 1'b0;
    endcase

    bad_idx = (use_rd  && {1'b0, rd}  >= NREG_LIM) ||
              (use_rs1 && {1'b0, rs1} >= NREG_LIM) ||
              (use_rs2 && {1'b0, rs2} >= NREG_LIM);
    d_illegal = !known || bad_idx;
    // An illegal instruction must have no architectural side effect.
    if (d_illegal) begin
      d_wben = 1'b0;
      d_mw   = 1'b0;
      d_runf = 1'b0;
    end
  end

  // Sign extension from bit 31 also covers LUI/AUIPC on 64-bit datapaths.
  assign d_imm  = XLEN'($signed(imm32));
  assign d_ctrl = {i_instr[30], i_instr[14:12], d_illegal, d_runf, d_ebreak,
                   d_wben, d_wbsel, d_mw, d_br, d_alu, d_r2sel, d_r1sel};

  // ------------------------------------------------------------ filter FSM
  filt_state_e   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_filt_err <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      o_filt_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = o_filt_err;
    case (state)
      IDLE: begin
        // d_runf is already cleared for illegal encodings.
        if (!stall && !flush && d_runf) begin
          state_next = BUSY;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        // done is checked first so a coincident timeout leaves the flag alone.
        if (i_filt_done) begin
          state_next = IDLE;
        end else if (cnt == TMO_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_stall_req = (state == BUSY);
  assign o_filt_busy = (state == BUSY);

  // ------------------------------------------------------- pipeline regs
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc <= '0; o_pc4 <= '0; o_reg1 <= '0; o_reg2 <= '0; o_imm <= '0;
      o_ctrl <= '0; o_w_idx <= '0; o_rs1 <= '0; o_rs2 <= '0;
    end else if (stall) begin
      // hold every output
    end else if (flush || state == BUSY) begin
      o_pc <= '0; o_pc4 <= '0; o_reg1 <= '0; o_reg2 <= '0; o_imm <= '0;
      o_ctrl <= '0; o_w_idx <= '0; o_rs1 <= '0; o_rs2 <= '0;
    end else begin
      o_pc    <= i_pc;
      o_pc4   <= i_pc4;
      o_reg1  <= rs1_val;
      o_reg2  <= rs2_val;
      o_imm   <= d_imm;
      o_ctrl  <= d_ctrl;
      o_w_idx <= rd;
      o_rs1   <= rs1;
      o_rs2   <= rs2;
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p
//   Two instances of decode_stage_p share one stimulus stream:
//     a: XLEN=32, NREG=32, FILT_TIMEOUT=8
//     b: XLEN=64, NREG=16 (RV32E), FILT_TIMEOUT=256
//   A reference model (instruction-format table, array register file,
//   cycle-stamped filter busy window) predicts every output.
module tb_decode_stage_p;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, wr_en, filt_done;
  logic [31:0] instr;
  logic [63:0] pc, pc4, wr_data;
  logic [4:0]  wr_idx;

  logic [31:0] a_pc, a_pc4, a_reg1, a_reg2, a_imm, a_reg_a0;
  logic [16:0] a_ctrl;
  logic [4:0]  a_w_idx, a_rs1, a_rs2, a_wire_rs1, a_wire_rs2;
  logic        a_stall_req, a_filt_busy, a_filt_err;

  logic [63:0] b_pc, b_pc4, b_reg1, b_reg2, b_imm, b_reg_a0;
  logic [16:0] b_ctrl;
  logic [4:0]  b_w_idx, b_rs1, b_rs2, b_wire_rs1, b_wire_rs2;
  logic        b_stall_req, b_filt_busy, b_filt_err;

  decode_stage_p #(.XLEN(32), .NREG(32), .FILT_TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_instr(instr),
    .i_pc(pc[31:0]), .i_pc4(pc4[31:0]), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
    .i_wr_data(wr_data[31:0]), .i_filt_done(filt_done),
    .o_pc(a_pc), .o_pc4(a_pc4), .o_reg1(a_reg1), .o_reg2(a_reg2), .o_imm(a_imm),
    .o_ctrl(a_ctrl), .o_w_idx(a_w_idx), .o_rs1(a_rs1), .o_rs2(a_rs2),
    .o_wire_rs1(a_wire_rs1), .o_wire_rs2(a_wire_rs2), .o_reg_a0(a_reg_a0),
    .o_stall_req(a_stall_req), .o_filt_busy(a_filt_busy), .o_filt_err(a_filt_err)
  );

  decode_stage_p #(.XLEN(64), .NREG(16), .FILT_TIMEOUT(256)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .i_instr(instr),
    .i_pc(pc), .i_pc4(pc4), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
    .i_wr_data(wr_data), .i_filt_done(filt_done),
    .o_pc(b_pc), .o_pc4(b_pc4), .o_reg1(b_reg1), .o_reg2(b_reg2), .o_imm(b_imm),
    .o_ctrl(b_ctrl), .o_w_idx(b_w_idx), .o_rs1(b_rs1), .o_rs2(b_rs2),
    .o_wire_rs1(b_wire_rs1), .o_wire_rs2(b_wire_rs2), .o_reg_a0(b_reg_a0),
    .o_stall_req(b_stall_req), .o_filt_busy(b_filt_busy), .o_filt_err(b_filt_err)
  );

  // ------------------------------------------------------------ scoreboard
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ----------------------------------------------------- reference model
  typedef struct packed {
    logic [63:0] pc, pc4, reg1, reg2, imm;
    logic [16:0] ctrl;
    logic [4:0]  w_idx, rs1, rs2;
  } pipe_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [16:0] ctrl;
  } dec_t;

  logic [63:0] m_rf    [2][32];
  pipe_t       m_pipe  [2];
  logic        m_busy  [2];
  logic        m_err   [2];
  int          m_start [2];
  int          cycle = 0;

  function automatic int k_nreg(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int k_tmo(input int k);
    return (k == 0) ? 8 : 256;
  endfunction

  function automatic logic [63:0] k_mask(input int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Architectural read: x0 and nonexistent registers are zero; a write that
  // actually lands this edge is visible to the same-cycle read.
  function automatic logic [63:0] m_read(input int k, input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= k_nreg(k)) return '0;
    if (wr_en && idx == wr_idx) return wr_data & k_mask(k);
    return m_rf[k][idx];
  endfunction

  // Decoder from the instruction-format table.
  function automatic dec_t ref_decode(input logic [31:0] ins, input int nreg);
    dec_t d;
    logic r1 = 0, r2 = 0, mw = 0, wb = 0, eb = 0, rf = 0, known = 1;
    logic u_rd = 0, u_1 = 0, u_2 = 0, ill;
    logic [1:0] alu = 0, br = 0, ws = 0;
    logic signed [63:0] imm = 0;
    case (ins[6:0])
      7'h33: begin alu = 1; wb = 1; u_rd = 1; u_1 = 1; u_2 = 1; end
      7'h13: begin r2 = 1; alu = 2; wb = 1; u_rd = 1; u_1 = 1; imm = $signed(ins[31:20]); end
      7'h03: begin r2 = 1; ws = 1; wb = 1; u_rd = 1; u_1 = 1; imm = $signed(ins[31:20]); end
      7'h23: begin r2 = 1; mw = 1; u_1 = 1; u_2 = 1; imm = $signed({ins[31:25], ins[11:7]}); end
      7'h63: begin r1 = 1; r2 = 1; br = 1; u_1 = 1; u_2 = 1;
                   imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2; end
      7'h6F: begin r1 = 1; r2 = 1; br = 2; ws = 2; wb = 1; u_rd = 1;
                   imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; end
      7'h67: begin r2 = 1; br = 3; ws = 2; wb = 1; u_rd = 1; u_1 = 1; imm = $signed(ins[31:20]); end
      7'h37: begin r2 = 1; alu = 3; wb = 1; u_rd = 1; imm = $signed(ins[31:12]) * 4096; end
      7'h17: begin r1 = 1; r2 = 1; wb = 1; u_rd = 1; imm = $signed(ins[31:12]) * 4096; end
      7'h73: eb = (ins == 32'h0010_0073);
      7'h0B: begin rf = 1; u_1 = 1; u_2 = 1; end
      default: known = 0;
    endcase
    ill = !known || (u_rd && int'(ins[11:7]) >= nreg) ||
          (u_1 && int'(ins[19:15]) >= nreg) || (u_2 && int'(ins[24:20]) >= nreg);
    if (ill) begin wb = 0; mw = 0; rf = 0; end
    d.imm  = imm;
    d.ctrl = {ins[30], ins[14:12], ill, rf, eb, wb, ws, mw, br, alu, r2, r1};
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) m_rf[k][r] = '0;
      m_pipe[k] = '0; m_busy[k] = 1'b0; m_err[k] = 1'b0; m_start[k] = 0;
    end
  endtask

  // One clock: check combinational outputs, predict, clock, check registers.
  task automatic tick();
    pipe_t       cand;
    pipe_t       nxt    [2];
    logic        nbusy  [2];
    logic        nerr   [2];
    int          nstart [2];
    dec_t        d;
    logic [63:0] ea0, eb0, mask;
    #1;
    ea0 = m_read(0, 5'd10);
    eb0 = m_read(1, 5'd10);
    chk("a_comb", {a_wire_rs1, a_wire_rs2, a_reg_a0}, {instr[19:15], instr[24:20], ea0[31:0]});
    chk("b_comb", {b_wire_rs1, b_wire_rs2, b_reg_a0}, {instr[19:15], instr[24:20], eb0});
    for (int k = 0; k < 2; k++) begin
      mask       = k_mask(k);
      d          = ref_decode(instr, k_nreg(k));
      cand.pc    = pc & mask;
      cand.pc4   = pc4 & mask;
      cand.reg1  = m_read(k, instr[19:15]);
      cand.reg2  = m_read(k, instr[24:20]);
      cand.imm   = d.imm & mask;
      cand.ctrl  = d.ctrl;
      cand.w_idx = instr[11:7];
      cand.rs1   = instr[19:15];
      cand.rs2   = instr[24:20];
      if (rst)                       nxt[k] = '0;
      else if (stall)                nxt[k] = m_pipe[k];
      else if (flush || m_busy[k])   nxt[k] = '0;
      else                           nxt[k] = cand;
      nbusy[k] = m_busy[k]; nerr[k] = m_err[k]; nstart[k] = m_start[k];
      if (rst) begin
        nbusy[k] = 1'b0; nerr[k] = 1'b0;
      end else if (m_busy[k]) begin
        // busy window closes on done, or once it has lasted FILT_TIMEOUT cycles
        if (filt_done) nbusy[k] = 1'b0;
        else if (cycle - m_start[k] == k_tmo(k)) begin nbusy[k] = 1'b0; nerr[k] = 1'b1; end
      end else if (!stall && !flush && d.ctrl[11]) begin
        nbusy[k] = 1'b1; nstart[k] = cycle;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_pipe[k] = nxt[k]; m_busy[k] = nbusy[k]; m_err[k] = nerr[k]; m_start[k] = nstart[k];
      if (rst) for (int r = 0; r < 32; r++) m_rf[k][r] = '0;
      else if (wr_en && wr_idx != 5'd0 && int'(wr_idx) < k_nreg(k))
        m_rf[k][wr_idx] = wr_data & k_mask(k);
    end
    cycle++;
    chk("a_pipe", {32'b0, a_pc, 32'b0, a_pc4, 32'b0, a_reg1, 32'b0, a_reg2, 32'b0, a_imm,
                   a_ctrl, a_w_idx, a_rs1, a_rs2}, m_pipe[0]);
    chk("b_pipe", {b_pc, b_pc4, b_reg1, b_reg2, b_imm, b_ctrl, b_w_idx, b_rs1, b_rs2}, m_pipe[1]);
    chk("a_fsm", {a_stall_req, a_filt_busy, a_filt_err}, {m_busy[0], m_busy[0], m_err[0]});
    chk("b_fsm", {b_stall_req, b_filt_busy, b_filt_err}, {m_busy[1], m_busy[1], m_err[1]});
  endtask

  // ---------------------------------------------------------- stimulus gen
  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                             7'h67, 7'h37, 7'h17, 7'h73, 7'h0B};
    logic [31:0] w   = $urandom;
    int          sel = $urandom_range(0, 12);
    if (sel == 12) return 32'h0010_0073;
    if (sel < 11) w[6:0] = ops[sel];
    if ($urandom_range(0, 1) == 1) begin w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0; end
    return w;
  endfunction

  localparam logic [31:0] ADD_X6_X5_X5 = {7'b0, 5'd5, 5'd5, 3'b0, 5'd6, 7'b0110011};
  localparam logic [31:0] ADDI_X20     = {12'd1, 5'd1, 3'b0, 5'd20, 7'b0010011};
  localparam logic [31:0] ADD_X7_X20   = {7'b0, 5'd0, 5'd20, 3'b0, 5'd7, 7'b0110011};
  localparam logic [31:0] FILTER_I     = {7'b0, 5'd2, 5'd1, 3'b0, 5'd3, 7'b0001011};
  localparam logic [31:0] ADDI_X3      = {12'd7, 5'd2, 3'b0, 5'd3, 7'b0010011};
  localparam logic [31:0] LUI_12345    = {20'h12345, 5'd1, 7'b0110111};
  localparam logic [31:0] LUI_80000    = {20'h80000, 5'd1, 7'b0110111};

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; wr_en = 1'b0; filt_done = 1'b0;
    instr = 32'h0000_0013; pc = 64'h1000; pc4 = 64'h1004; wr_idx = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    tick();                                  // reset state
    rst = 1'b0;

    // write/read bypass: x5 written while add x6,x5,x5 reads it
    instr = ADD_X6_X5_X5; wr_en = 1'b1; wr_idx = 5'd5; wr_data = 64'h0000_0000_DEAD_BEEF;
    tick();
    chk("bypass_a_reg1", a_reg1, 32'hDEAD_BEEF);
    chk("bypass_a_reg2", a_reg2, 32'hDEAD_BEEF);
    chk("bypass_b_reg1", b_reg1, 64'hDEAD_BEEF);

    // RV32E: x20 is illegal on b, legal on a
    instr = ADDI_X20; wr_idx = 5'd20; wr_data = 64'h1234;
    tick();
    chk("rv32e_b_illegal", {b_ctrl[12], b_ctrl[9]}, 2'b10);
    chk("rv32e_a_legal", {a_ctrl[12], a_ctrl[9]}, 2'b01);
    instr = ADD_X7_X20; wr_en = 1'b0;
    tick();
    chk("rv32e_b_x20", b_reg1, 64'h0);
    chk("rv32e_a_x20", a_reg1, 32'h1234);

    // filter completes on a done pulse after five quiet cycles
    instr = FILTER_I;
    tick();
    n = a_stall_req ? 1 : 0;
    instr = ADDI_X3;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_stall_req) n++;
      chk("filt_bubble", a_ctrl, 17'h0);
    end
    filt_done = 1'b1;
    tick();
    filt_done = 1'b0;
    chk("filt_done_stall", {a_stall_req, b_stall_req}, 2'b00);
    chk("filt_stall_cycles", n, 6);
    chk("filt_no_err", a_filt_err, 1'b0);
    tick();

    // filter timeout on a (8 cycles), sticky error
    instr = FILTER_I;
    tick();
    n = a_filt_busy ? 1 : 0;
    instr = ADDI_X3;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_filt_busy) n++;
    end
    chk("tmo_busy_cycles", n, 8);
    chk("tmo_err", a_filt_err, 1'b1);
    filt_done = 1'b1;                        // ends b; a is idle and ignores it
    tick();
    filt_done = 1'b0;
    tick();
    chk("tmo_err_sticky", {a_filt_err, a_filt_busy}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tmo_err_cleared", a_filt_err, 1'b0);

    // reset in the third busy cycle
    pc = 64'h2000; pc4 = 64'h2004;
    wr_en = 1'b1; wr_idx = 5'd10; wr_data = 64'h55;
    instr = FILTER_I;
    tick();
    wr_en = 1'b0;
    instr = ADDI_X3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy_fsm", {a_stall_req, a_filt_busy, b_stall_req}, 3'b000);
    chk("rst_busy_outs", {a_pc, a_reg1, a_imm, a_ctrl, a_w_idx}, 0);
    chk("rst_busy_rf_a0", a_reg_a0, 32'h0);

    // stall beats flush; then flush alone loads a bubble
    instr = ADD_X6_X5_X5;
    tick();
    stall = 1'b1; flush = 1'b1; instr = LUI_12345;
    tick();
    chk("stall_hold_widx", a_w_idx, 5'd6);
    chk("stall_hold_pc", a_pc, 32'h2000);
    stall = 1'b0;
    tick();
    chk("flush_bubble", {a_pc, a_ctrl, a_imm}, 0);
    flush = 1'b0;
    tick();
    chk("lui_imm_a", a_imm, 32'h1234_5000);
    chk("lui_widx", {a_w_idx, a_ctrl[9]}, {5'd1, 1'b1});
    instr = LUI_80000;
    tick();
    chk("lui_imm_b_sext", b_imm, 64'hFFFF_FFFF_8000_0000);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      filt_done = ($urandom_range(0, 5) == 0);
      instr     = gen_instr();
      pc        = {$urandom, $urandom};
      pc4       = pc + 64'd4;
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_idx    = ($urandom_range(0, 3) == 0) ? instr[19:15] : 5'($urandom_range(0, 31));
      wr_data   = {$urandom, $urandom};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameter XLEN, default 32: datapath width for pc, register and immediate values; legal values 32 and 64.
REQ-002 Parameter NREG, default 32: architectural register count; 16 selects RV32E.
REQ-003 Parameter FILT_TIMEOUT, default 256: maximum cycles the stage waits for filter completion.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 stall  in  1  hold all pipeline outputs.
REQ-007 flush  in  1  load a bubble into the pipeline outputs.
REQ-008 i_instr  in  32  instruction word.
REQ-009 i_pc  in  XLEN  pc of the instruction.
REQ-010 i_pc4  in  XLEN  pc+4 of the instruction.
REQ-011 i_wr_en  in  1  writeback enable.
REQ-012 i_wr_idx  in  5  writeback register index.
REQ-013 i_wr_data  in  XLEN  writeback data.
REQ-014 i_filt_done  in  1  one-cycle completion pulse from the filter unit.
REQ-015 o_pc, o_pc4, o_reg1, o_reg2, o_imm  out  XLEN each  registered values passed to EX.
REQ-016 o_ctrl  out  17  registered control bus: [0] reg1_sel, [1] reg2_sel, [3:2] alu_op, [5:4] branch_op, [6] mem_w_en, [8:7] wb_sel, [9] wb_en, [10] ebreak, [11] run_filter, [12] illegal, [15:13] func3, [16] instr30.
REQ-017 o_w_idx, o_rs1, o_rs2  out  5 each  registered rd, rs1 and rs2 indices.
REQ-018 o_wire_rs1, o_wire_rs2  out  5 each  combinational rs1 and rs2 fields of i_instr, for hazard detection.
REQ-019 o_reg_a0  out  XLEN  combinational value of x10.
REQ-020 o_stall_req  out  1  requests an upstream stall while the filter is busy.
REQ-021 o_filt_busy  out  1  filter FSM is in state BUSY.
REQ-022 o_filt_err  out  1  sticky flag: filter timeout occurred.

Function
REQ-023 Pipeline-register priority, highest first: rst, then stall (hold), then flush or filter-busy (bubble: all outputs 0), then load decoded values.
REQ-024 Control encodings match the existing RV32I-plus-FILTER decoder: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, and FILTER 0001011.
REQ-025 An unknown opcode, or any used rs1/rs2/rd index >= NREG, sets illegal=1 and forces wb_en=0, mem_w_en=0 and run_filter=0.
REQ-026 Immediates are sign-extended to XLEN; for LUI and AUIPC, bits above 31 equal bit 31.
REQ-027 Register file: x0 reads 0 and ignores writes; a write occurs at the edge when i_wr_en=1 and 0<i_wr_idx<NREG.
REQ-028 Register file bypass: a same-cycle read of i_wr_idx returns i_wr_data; o_reg_a0 also bypasses.
REQ-029 Filter FSM states are IDLE and BUSY; the timeout counter width is clog2(FILT_TIMEOUT)+1.
REQ-030 IDLE->BUSY at the edge that loads a FILTER instruction with run_filter=1 (stall=0, flush=0, legal); the counter is cleared on that edge.
REQ-031 In BUSY the counter increments each cycle; o_stall_req=1, o_filt_busy=1, and bubbles are loaded unless stall=1.
REQ-032 BUSY->IDLE at the edge where i_filt_done=1; o_stall_req is 0 from that edge.
REQ-033 BUSY->IDLE when the counter equals FILT_TIMEOUT-1 without done, setting o_filt_err=1 until rst.
REQ-034 If done and timeout coincide, done wins and o_filt_err is unchanged.
REQ-035 i_filt_done in IDLE is ignored.
REQ-036 flush during BUSY does not abort the FSM.

Reset
REQ-037 rst=1 at a clock edge clears all outputs, all registers x1..x(NREG-1), the counter and o_filt_err, and sets the FSM to IDLE, including mid-BUSY.

Verification
REQ-038 Write x5=0xDEADBEEF while decoding "add x6,x5,x5" in the same cycle -> next edge o_reg1=o_reg2=0xDEADBEEF.
REQ-039 NREG=16, decode "addi x20,x1,1" -> o_ctrl[12]=1 and wb_en=0; write to x20 -> x20 unchanged.
REQ-040 Issue FILTER, hold i_filt_done low 5 cycles, then pulse it -> o_stall_req=1 for exactly 6 cycles, bubbles in EX, o_filt_err=0.
REQ-041 FILT_TIMEOUT=8, never assert done -> BUSY for 8 cycles, then IDLE with o_filt_err=1, sticky until rst.
REQ-042 rst asserted in the 3rd BUSY cycle -> next edge IDLE, all outputs 0, o_stall_req=0.
REQ-043 stall=1 and flush=1 together with valid instruction "lui x1,0x12345" -> outputs held; after stall drops with flush=1 -> bubble loaded.
